sensor_conditioner: RTL and testbench

- Front-end stage that sits directly upstream of the home automation controller.
- Synchronises and debounces the four raw binary sensors (front door, rear door, window, fire alarm).
- Samples the raw 8-bit temperature bus at a fixed rate and presents a rounded 4-sample moving average.
- Its outputs connect directly to the controller inputs SFD, SRD, SW, SFA and ST[7:0].

---
 rtl/sensor_pkg.sv | 20 ++
 rtl/sensor_conditioner_if.sv | 28 ++
 rtl/sensor_conditioner_debounce_chan.sv | 47 ++++
 rtl/sensor_conditioner.sv | 111 +++++++++++
 tb/tb_sensor_conditioner.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor front-end conditioner.
package sensor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } temp_state_t;

    localparam int DEB_CYCLES_DEF = 16;
    localparam int SAMPLE_DIV_DEF = 1000;
    localparam int AVG_DEPTH      = 4;
    localparam int AVG_SHIFT      = 2;

    localparam int EVT_FD = 0;
    localparam int EVT_RD = 1;
    localparam int EVT_W  = 2;
    localparam int EVT_FA = 3;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Raw sensor inputs and conditioned outputs feeding the home automation controller.
interface sensor_conditioner_if;

    logic       raw_fd;
    logic       raw_rd;
    logic       raw_w;
    logic       raw_fa;
    logic [7:0] raw_temp;

    logic       SFD;
    logic       SRD;
    logic       SW;
    logic       SFA;
    logic [7:0] ST;
    logic       st_valid;
    logic [3:0] sensor_evt;

    modport master (
        output raw_fd, raw_rd, raw_w, raw_fa, raw_temp,
        input  SFD, SRD, SW, SFA, ST, st_valid, sensor_evt
    );

    modport slave (
        input  raw_fd, raw_rd, raw_w, raw_fa, raw_temp,
        output SFD, SRD, SW, SFA, ST, st_valid, sensor_evt
    );

endinterface

// File: rtl/sensor_conditioner_debounce_chan.sv
// One binary sensor channel: 2-flop synchroniser, stability counter, edge pulse.
module debounce_chan
    import sensor_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_q,
    output logic o_evt
);

    logic       r_s1;
    logic       r_s2;
    logic       r_q;
    logic       r_evt;
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_q   <= 1'b0;
            r_evt <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1  <= i_raw;
            r_s2  <= r_s1;
            r_evt <= 1'b0;
            // Any cycle where the synchronised level agrees with q restarts the window.
            if (r_s2 == r_q) begin
                r_cnt <= '0;
            end else if (r_cnt == 8'(DEB_CYCLES - 1)) begin
                r_q   <= ~r_q;
                r_cnt <= '0;
                r_evt <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign o_q   = r_q;
    assign o_evt = r_evt;

endmodule

// File: rtl/sensor_conditioner.sv
// Sensor front end: debounces four binary sensors and presents a rounded
// 4-sample moving average of the temperature bus at a fixed sample rate.
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 Rst,
    sensor_conditioner_if.slave  bus
);

    // Round-half-up average; a 4 x 255 sum plus 2 still fits 10 bits.
    function automatic logic [7:0] avg_round(input logic [9:0] sum);
        logic [9:0] t;
        t = (sum + 10'd2) >> AVG_SHIFT;
        return t[7:0];
    endfunction

    logic [3:0] w_raw;
    logic [3:0] w_q;
    logic [3:0] w_evt;

    assign w_raw[EVT_FD] = bus.raw_fd;
    assign w_raw[EVT_RD] = bus.raw_rd;
    assign w_raw[EVT_W]  = bus.raw_w;
    assign w_raw[EVT_FA] = bus.raw_fa;

    for (genvar g = 0; g < 4; g++) begin : g_chan
        debounce_chan #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_chan (
            .clk   (clk),
            .rst   (Rst),
            .i_raw (w_raw[g]),
            .o_q   (w_q[g]),
            .o_evt (w_evt[g])
        );
    end

    assign bus.SFD        = w_q[EVT_FD];
    assign bus.SRD        = w_q[EVT_RD];
    assign bus.SW         = w_q[EVT_W];
    assign bus.SFA        = w_q[EVT_FA];
    assign bus.sensor_evt = w_evt;

    logic [15:0]  r_div;
    logic [7:0]   r_temp;
    logic [7:0]   r_buf [AVG_DEPTH];
    temp_state_t  r_state;
    logic [7:0]   r_st;
    logic         r_st_valid;
    logic         w_tick;
    logic [9:0]   w_sum;

    assign w_tick = (r_div == 16'(SAMPLE_DIV - 1));

    // Sum of the window as it will look once the captured sample is shifted in.
    assign w_sum = 10'(r_temp) + 10'(r_buf[0]) + 10'(r_buf[1]) + 10'(r_buf[2]);

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_div      <= '0;
            r_temp     <= '0;
            r_state    <= IDLE;
            r_st       <= '0;
            r_st_valid <= 1'b0;
            for (int i = 0; i < AVG_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_temp     <= bus.raw_temp;
            r_div      <= w_tick ? '0 : r_div + 16'd1;
            r_st_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // First sample after reset fills the whole window so ST starts at the true value.
                    if (w_tick) begin
                        for (int i = 0; i < AVG_DEPTH; i++) begin
                            r_buf[i] <= r_temp;
                        end
                        r_st       <= r_temp;
                        r_st_valid <= 1'b1;
                        r_state    <= PRIME;
                    end
                end
                PRIME: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (w_tick) begin
                        r_buf[0]   <= r_temp;
                        r_buf[1]   <= r_buf[0];
                        r_buf[2]   <= r_buf[1];
                        r_buf[3]   <= r_buf[2];
                        r_st       <= avg_round(w_sum);
                        r_st_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ST       = r_st;
    assign bus.st_valid = r_st_valid;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with a scoreboard for the temperature averager.
module tb_sensor_conditioner;
    import sensor_pkg::*;

    localparam int DEB = 4;
    localparam int DIV = 8;

    logic clk = 1'b0;
    logic Rst;
    always #5 clk = ~clk;

    sensor_conditioner_if bus();

    sensor_conditioner #(
        .DEB_CYCLES (DEB),
        .SAMPLE_DIV (DIV)
    ) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model of the sampler/averager; pushes expected ST values on each tick.
    logic [7:0] q_exp[$];
    logic [7:0] st_hold = 8'd0;
    bit         mon_en  = 1'b0;

    initial begin
        int         m_div;
        bit         m_primed;
        logic [7:0] m_rtemp;
        logic [7:0] m_buf [4];
        int         sum;
        m_div    = 0;
        m_primed = 1'b0;
        m_rtemp  = 8'd0;
        for (int i = 0; i < 4; i++) m_buf[i] = 8'd0;
        forever begin
            @(posedge clk);
            if (Rst === 1'b1) begin
                m_div    = 0;
                m_primed = 1'b0;
                m_rtemp  = 8'd0;
                for (int i = 0; i < 4; i++) m_buf[i] = 8'd0;
                st_hold  = 8'd0;
            end else begin
                if (m_div == DIV - 1) begin
                    if (!m_primed) begin
                        for (int i = 0; i < 4; i++) m_buf[i] = m_rtemp;
                        q_exp.push_back(m_rtemp);
                        m_primed = 1'b1;
                    end else begin
                        m_buf[3] = m_buf[2];
                        m_buf[2] = m_buf[1];
                        m_buf[1] = m_buf[0];
                        m_buf[0] = m_rtemp;
                        sum = int'(m_buf[0]) + int'(m_buf[1]) + int'(m_buf[2]) + int'(m_buf[3]);
                        q_exp.push_back(8'((sum + 2) / 4));
                    end
                    m_div = 0;
                end else begin
                    m_div++;
                end
                m_rtemp = bus.raw_temp;
            end
        end
    end

    // Scoreboard monitor: pops on st_valid, checks ST hold value every cycle.
    initial begin
        bit prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.st_valid === 1'b1) begin
                    check("st_valid_back_to_back", prev_v, 0);
                    check("st_valid_expected", (q_exp.size() > 0), 1);
                    if (q_exp.size() > 0) st_hold = q_exp.pop_front();
                end
                check("ST_scoreboard", bus.ST, st_hold);
                prev_v = (bus.st_valid === 1'b1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(output logic [7:0] st, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        st     = 8'd0;
        while (!found && cycles < 24) begin
            @(negedge clk);
            cycles++;
            if (bus.st_valid === 1'b1) begin
                found = 1'b1;
                st    = bus.ST;
            end
        end
        check("st_valid_timeout", found, 1);
    endtask

    function automatic logic [16:0] all_outs();
        return {bus.SFD, bus.SRD, bus.SW, bus.SFA, bus.ST, bus.st_valid, bus.sensor_evt};
    endfunction

    initial begin
        logic [7:0] st;
        int         c;
        logic [7:0] fall_exp [4];
        fall_exp[0] = 8'd191;
        fall_exp[1] = 8'd128;
        fall_exp[2] = 8'd64;
        fall_exp[3] = 8'd0;

        Rst          = 1'b1;
        bus.raw_fd   = 1'b1;
        bus.raw_rd   = 1'b1;
        bus.raw_w    = 1'b1;
        bus.raw_fa   = 1'b1;
        bus.raw_temp = 8'hFF;

        // Reset held three cycles with all raw inputs high.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            mon_en = 1'b1;
            check("reset_outputs_zero", all_outs(), 0);
        end
        Rst          = 1'b0;
        bus.raw_fd   = 1'b0;
        bus.raw_rd   = 1'b0;
        bus.raw_w    = 1'b0;
        bus.raw_fa   = 1'b0;
        bus.raw_temp = 8'd40;

        wait_valid(st, c);
        check("prime_40", st, 40);
        bus.raw_temp = 8'd44;
        wait_valid(st, c);
        check("avg_41", st, 41);
        check("spacing_41", c, DIV);
        bus.raw_temp = 8'd48;
        wait_valid(st, c);
        check("avg_43", st, 43);
        check("spacing_43", c, DIV);

        bus.raw_temp = 8'd255;
        for (int k = 0; k < 5; k++) wait_valid(st, c);
        check("avg_255_no_wrap", st, 255);
        bus.raw_temp = 8'd0;
        for (int k = 0; k < 4; k++) begin
            wait_valid(st, c);
            check("avg_falling", st, fall_exp[k]);
        end

        // Front-door glitch shorter than the debounce window.
        bus.raw_fd = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 3) bus.raw_fd = 1'b0;
            check("fd_glitch_q", bus.SFD, 0);
            check("fd_glitch_evt", bus.sensor_evt[EVT_FD], 0);
        end

        // Fire alarm rise then fall, each edge counted from the first sampling edge.
        bus.raw_fa = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("fa_rise_q", bus.SFA, (k >= DEB + 2));
            check("fa_rise_evt", bus.sensor_evt, (k == DEB + 2) ? 4'b1000 : 4'b0000);
        end
        bus.raw_fa = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("fa_fall_q", bus.SFA, (k < DEB + 2));
            check("fa_fall_evt", bus.sensor_evt, (k == DEB + 2) ? 4'b1000 : 4'b0000);
        end

        // Mixed window, then reset mid-debounce and mid-average.
        bus.raw_temp = 8'd100;
        wait_valid(st, c);
        check("avg_25", st, 25);
        bus.raw_w = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("w_pre_reset_q", bus.SW, 0);
        end
        Rst          = 1'b1;
        bus.raw_w    = 1'b0;
        bus.raw_temp = 8'd77;
        @(posedge clk);
        @(negedge clk);
        check("midreset_outputs_zero", all_outs(), 0);
        Rst = 1'b0;
        wait_valid(st, c);
        check("reprime_77", st, 77);
        check("reprime_spacing", c, DIV);
        check("w_no_flip_q", bus.SW, 0);
        check("w_no_flip_evt", bus.sensor_evt, 0);

        @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
